dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the MEM-stage pipeline port (P) and a
//  loader/debug DMA port (D). Serialises accesses, stalls the pipeline while its access
//  is pending, and guarantees D progress with a starvation counter. Sits between the
//  MEM stage / DMA engine and the DATAMEM instance.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  MEM_LAT     1   cycles the memory command is held before rdata is sampled (>=1)
//  STARVE_MAX  4   consecutive P grants with D waiting before D is forced to win (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  p_req      in   1   pipeline access request (held stable until p_stall falls)
//  p_we       in   1   pipeline access is a write
//  p_addr     in   AW  pipeline address (ALU result)
//  p_wdata    in   DW  pipeline store data
//  p_rdata    out  DW  pipeline load data, valid when p_req=1 and p_stall=0
//  p_stall    out  1   freeze pipeline; high while p_req=1 and P access not complete
//  d_req      in   1   DMA access request (held until d_ack)
//  d_we       in   1   DMA access is a write
//  d_addr     in   AW  DMA address
//  d_wdata    in   DW  DMA write data
//  d_rdata    out  DW  DMA read data, valid in d_ack cycle
//  d_ack      out  1   one-cycle completion pulse for DMA access
//  mem_rd     out  1   DATAMEM MemRead
//  mem_wr     out  1   DATAMEM MemWrite
//  mem_addr   out  AW  DATAMEM Addr
//  mem_wdata  out  DW  DATAMEM Wdata
//  mem_rdata  in   DW  DATAMEM Rdata
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, lat_cnt=0, starve=0, owner=P; p_rdata=0, d_rdata=0,
//   d_ack=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. p_stall=p_req (combinational).
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: grant if any req. D wins iff d_req & (!p_req | starve==STARVE_MAX); else P.
//    On grant latch owner, we, addr, wdata; lat_cnt=0; -> BUSY.
//   BUSY: drive mem_addr/mem_wdata from latch, mem_rd=!we, mem_wr=we (registered outputs,
//    zero in every other state). lat_cnt++ each cycle; in cycle lat_cnt==MEM_LAT-1 capture
//    mem_rdata (reads only) into owner's rdata register; -> DONE.
//   DONE: P owner: p_stall=0 this cycle (pipeline advances on this edge). D owner: d_ack=1.
//    -> IDLE. No grant is made in DONE (one bubble between accesses).
//  p_stall = p_req & !(state==DONE & owner==P). Stall cycles for isolated P access
//   = MEM_LAT+1; completion latency = MEM_LAT+2 cycles from request.
//  starve: on P grant with d_req=1, starve=min(starve+1,STARVE_MAX); on D grant, starve=0;
//   P grant with d_req=0 leaves starve unchanged.
//  Requests are latched at grant; deassertion of p_req/d_req during BUSY does not abort
//   (access completes, write commits, ack/rdata still produced).
//  Writes: mem_wr high for all MEM_LAT BUSY cycles, same addr/data (idempotent).
//  p_rdata/d_rdata hold last captured value until next read by the same owner; writes
//   do not alter them.
//  Same-address P/D collisions: strictly serialised in grant order; no forwarding.
//  Reset mid-access: access aborted, no ack, write may or may not have committed; requester
//   re-issues after reset.
// TESTING
//  T1 MEM_LAT=1: P read addr 0x10 (mem holds 0xDEADBEEF) -> p_stall high 2 cycles, low in
//   cycle 3 with p_rdata=0xDEADBEEF; mem_rd high exactly 1 cycle.
//  T2 D write 0x20<=0x12345678, then P read 0x20 -> d_ack single pulse; p_rdata=0x12345678.
//  T3 p_req and d_req both held continuously, STARVE_MAX=4 -> grant order P,P,P,P,D repeating;
//   starve returns to 0 after each D grant.
//  T4 MEM_LAT=3, P write 0x40<=0xA5A5A5A5 -> mem_wr high 3 cycles, p_stall high 4 cycles,
//   p_rdata unchanged.
//  T5 rst asserted mid-BUSY of D read -> all outputs 0 asynchronously, no d_ack; after
//   release re-issued read completes normally.
//  T6 d_req dropped during BUSY -> access still completes, d_ack pulses once, no second grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter between the MEM-stage pipeline port (P) and a DMA/debug port (D) for one
// single-port data memory. Accesses are serialised as IDLE -> BUSY -> DONE -> IDLE.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LCW = $clog2(MEM_LAT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // owner: 0 = pipeline port, 1 = DMA port
  state_t          state_q,     state_d;
  logic            owner_q,     owner_d;
  logic            we_q,        we_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic [LCW-1:0]  lat_q,       lat_d;
  logic [SCW-1:0]  starve_q,    starve_d;
  logic [DW-1:0]   p_rdata_q,   p_rdata_d;
  logic [DW-1:0]   d_rdata_q,   d_rdata_d;
  logic            d_ack_q,     d_ack_d;
  logic            mem_rd_q,    mem_rd_d;
  logic            mem_wr_q,    mem_wr_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            d_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    p_rdata_d   = p_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_ack_d     = 1'b0;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_win       = 1'b0;

    case (state_q)
      IDLE: begin
        if (p_req || d_req) begin
          // D only overtakes a waiting P once P has won STARVE_MAX times in a row
          d_win       = d_req && (!p_req || (starve_q == SCW'(STARVE_MAX)));
          owner_d     = d_win;
          we_d        = d_win ? d_we    : p_we;
          addr_d      = d_win ? d_addr  : p_addr;
          wdata_d     = d_win ? d_wdata : p_wdata;
          lat_d       = '0;
          state_d     = BUSY;
          mem_rd_d    = !we_d;
          mem_wr_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          if (d_win) begin
            starve_d = '0;
          end else if (d_req && (starve_q != SCW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      BUSY: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LCW'(MEM_LAT - 1)) begin
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         p_rdata_d = mem_rdata;
          end
          d_ack_d     = owner_q;
          state_d     = DONE;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      DONE: begin
        // Deliberate bubble: no grant here, so every access ends with one idle cycle
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      starve_q    <= '0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      p_rdata_q   <= p_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_ack_q     <= d_ack_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The pipeline advances on the edge that closes a P-owned DONE cycle
  assign p_stall   = p_req && !((state_q == DONE) && !owner_q);
  assign p_rdata   = p_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
